sysace_sram_loader: RTL
=======================

Name: sysace_sram_loader

Overview:
- Parametrised CompactFlash-to-SRAM loader that runs entirely in the CLK80 domain.
- Issues a sequence of multi-sector SystemACE read commands through a four-phase handshake to an external CLK33 command synchroniser.
- Pops 16-bit words from the async FIFO read side, repacks the byte stream into PIX_BYTES-wide pixels and writes them to the SRAM write port with address auto-increment.
- Also provides a fill mode that clears or patterns the whole SRAM before loading.

Parameters:
ADDR_W, 20, SRAM word-address width (wraps at 2^ADDR_W)
DATA_W, 32, SRAM write-data width
PIX_BYTES, 3, bytes per pixel, 1..4, PIX_BYTES*8 <= DATA_W; pixel zero-extended to DATA_W
NB_W, 16, width of burst counter

Ports:
CLK80  in  1  system clock
RST  in  1  reset; asynchronous, active-low
start  in  1  one-cycle start request; ignored while busy
mode  in  1  0 = load from card, 1 = fill SRAM
base_lba  in  28  first LBA, sampled at start
burst_sectors  in  8  sectors per command, 0 = 256; sampled at start
num_bursts  in  NB_W  commands to issue; 0 = finish immediately; sampled at start
base_addr  in  ADDR_W  first SRAM address for load; sampled at start
fill_pattern  in  DATA_W  fill value; sampled at start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on completion
partial  out  1  last load ended with 1..PIX_BYTES-1 unused bytes; held until next start
cmd_req  out  1  command request, four-phase
cmd_lba  out  28  command LBA; stable while cmd_req is high
cmd_nsectors  out  8  command sector count; stable while cmd_req is high
cmd_ack  in  1  acknowledge, already synchronised to CLK80
fifo_dout  in  16  FIFO data; valid the cycle after fifo_rd_en
fifo_empty  in  1  FIFO empty
fifo_rd_en  out  1  FIFO pop
wr_addr  out  ADDR_W  SRAM word address
wr_data  out  DATA_W  SRAM data
wr_en  out  1  write request
wr_full  in  1  write port back-pressure

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters and the byte accumulator cleared.
- Reset asserted mid-operation aborts immediately with no done pulse.
- Write handshake: a write is accepted in a cycle with wr_en && !wr_full. wr_addr and wr_data stay stable until accepted. Address increments by 1 per accepted write and wraps from 2^ADDR_W-1 to 0.
- States:
  - IDLE: on start, latch inputs and clear partial. Then mode=1 -> FILL; mode=0 && num_bursts!=0 -> CMD; otherwise -> DONE.
  - FILL: write fill_pattern to addresses 0..2^ADDR_W-1. After the final accepted write -> DONE.
  - CMD: cmd_req=1 with cmd_lba = current LBA and cmd_nsectors = burst_sectors. On cmd_ack=1, drop cmd_req -> ACKLOW.
  - ACKLOW: wait for cmd_ack=0. Load words_left = sectors*256 (sectors 0 means 256, so 65536 words; counter is 17 bits) -> XFER.
  - XFER: pop and pack words (rules below). When words_left=0, no read in flight and no pending write:
    - if bursts_left > 1: decrement bursts_left, LBA += sectors (28-bit wrap) -> CMD;
    - otherwise: partial = (bytes_held != 0), discard the leftover bytes -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Packing rules (XFER):
  - fifo_rd_en = !fifo_empty && words_left != 0 && no read in flight && no pending write.
  - Each returned word appends byte fifo_dout[7:0] first, then fifo_dout[15:8], to an accumulator of PIX_BYTES+1 bytes.
  - When bytes_held >= PIX_BYTES, the oldest PIX_BYTES bytes form a pending write. The first byte is the pixel MSB.
  - Leftover bytes carry across burst boundaries; the stream is contiguous.
  - Throughput is at most one FIFO word per 2 cycles.
- Simultaneous events: start during busy is ignored. wr_full held indefinitely stalls with no data loss and no extra pops. FIFO empty at a word boundary stalls XFER.

Decomposition:
- Shared package sysace_pkg: state encoding, SECTOR_WORDS=256, the nsectors-0-means-256 helper, LBA width 28.
- One sub-module, sysace_byte_packer: accumulator, pixel formation and pending-write register, parametrised by PIX_BYTES and DATA_W.
- Top level keeps the FSM, counters, command handshake and address generation.

Test Plan:
- Load: PIX_BYTES=3, base_lba=0x100, burst_sectors=1, num_bursts=1, base_addr=0, FIFO words 0x2211,0x4433,0x6655,... -> cmd_lba=0x100 and cmd_nsectors=1; first writes are 0x00112233@0, 0x00445566@1; 170 writes; partial=1 (512 mod 3 = 2); one done pulse.
- Multi-burst: burst_sectors=2, num_bursts=3, base_lba=0x10 -> cmd_lba sequence 0x10, 0x12, 0x14; 1536 words popped; PIX_BYTES=4 gives 768 writes and partial=0.
- Back-pressure: wr_full held high for 50 cycles mid-stream -> wr_addr/wr_data stable, fifo_rd_en=0 throughout, no write dropped or duplicated.
- Wrap and zero count: ADDR_W=4, base_addr=0xE, PIX_BYTES=2, burst_sectors=0 -> address sequence 0xE, 0xF, 0x0, ...; cmd_nsectors=0; 65536 words consumed.
- Fill and corner cases: mode=1, ADDR_W=4, fill_pattern=0xA5A5A5A5 -> 16 writes at 0..15 then done; start while busy is ignored; RST low mid-XFER -> all outputs 0 and no done pulse.

Source files
------------

// File: rtl/sysace_pkg.sv
// Shared definitions for the SystemACE CompactFlash-to-SRAM loader.
// Holds the FSM encoding, sector geometry and sector-count helpers.
package sysace_pkg;

   localparam int LBA_W        = 28;
   localparam int SECTOR_WORDS = 256;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_CMD,
      ST_ACKLOW,
      ST_XFER,
      ST_DONE
   } state_t;

   // A sector count of 0 on the command bus means 256 sectors.
   function automatic logic [8:0] sec_count(input logic [7:0] n);
      return (n == 8'd0) ? 9'd256 : {1'b0, n};
   endfunction

   function automatic logic [16:0] sec_words(input logic [7:0] n);
      return 17'(sec_count(n)) * 17'(SECTOR_WORDS);
   endfunction

endpackage

// File: rtl/sysace_byte_packer.sv
// Byte accumulator: packs 16-bit FIFO words (low byte first) into
// PIX_BYTES-wide pixels, first byte as MSB, and holds one pending write.
// Ports: i_clr clears everything, i_push appends i_word, i_pop retires the
// pending write; o_valid/o_data is the pending write, o_cnt the bytes held.
module sysace_byte_packer
   import sysace_pkg::*;
#(
   parameter int PIX_BYTES = 3,
   parameter int DATA_W    = 32
) (
   input  logic              CLK80,
   input  logic              RST,
   input  logic              i_clr,
   input  logic              i_push,
   input  logic [15:0]       i_word,
   input  logic              i_pop,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [2:0]        o_cnt
);

   logic [PIX_BYTES:0][7:0] r_acc;
   logic [PIX_BYTES:0][7:0] w_acc;
   logic [PIX_BYTES:0][7:0] w_acc_nx;
   logic [2:0]              r_cnt;
   logic [2:0]              w_cnt;
   logic [2:0]              w_cnt_nx;
   logic                    r_valid;
   logic                    w_valid_nx;
   logic [DATA_W-1:0]       r_data;
   logic [DATA_W-1:0]       w_data_nx;
   logic [DATA_W-1:0]       w_pix;

   always_comb begin
      w_acc = r_acc;
      w_cnt = r_cnt;
      if (i_push) begin
         for (int i = 0; i <= PIX_BYTES; i++) begin
            if (3'(i) == r_cnt)
               w_acc[i] = i_word[7:0];
            if (3'(i) == r_cnt + 3'd1)
               w_acc[i] = i_word[15:8];
         end
         w_cnt = r_cnt + 3'd2;
      end

      w_pix = '0;
      for (int i = 0; i < PIX_BYTES; i++)
         w_pix[(PIX_BYTES-1-i)*8 +: 8] = w_acc[i];

      w_acc_nx   = w_acc;
      w_cnt_nx   = w_cnt;
      w_valid_nx = r_valid;
      w_data_nx  = r_data;
      if (i_pop)
         w_valid_nx = 1'b0;
      // Reads only start with no pending write, so at most one byte can
      // remain after a pixel is taken; it moves to the head of the buffer.
      if ((!r_valid || i_pop) && w_cnt >= 3'(PIX_BYTES)) begin
         w_valid_nx  = 1'b1;
         w_data_nx   = w_pix;
         w_acc_nx    = '0;
         w_acc_nx[0] = w_acc[PIX_BYTES];
         w_cnt_nx    = w_cnt - 3'(PIX_BYTES);
      end
   end

   always_ff @(posedge CLK80 or negedge RST) begin
      if (!RST) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_clr) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_acc   <= w_acc_nx;
         r_cnt   <= w_cnt_nx;
         r_valid <= w_valid_nx;
         r_data  <= w_data_nx;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_cnt   = r_cnt;

endmodule

// File: rtl/sysace_sram_loader.sv
// CompactFlash-to-SRAM loader: issues multi-sector SystemACE reads over a
// four-phase req/ack, packs FIFO words into pixels and writes SRAM, or fills
// the whole SRAM with a pattern. Ports: start/mode/config in, busy/done/
// partial status, cmd_* handshake, fifo_* read side, wr_* SRAM write port.
module sysace_sram_loader
   import sysace_pkg::*;
#(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 32,
   parameter int PIX_BYTES = 3,
   parameter int NB_W      = 16
) (
   input  logic              CLK80,
   input  logic              RST,
   input  logic              start,
   input  logic              mode,
   input  logic [27:0]       base_lba,
   input  logic [7:0]        burst_sectors,
   input  logic [NB_W-1:0]   num_bursts,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DATA_W-1:0] fill_pattern,
   output logic              busy,
   output logic              done,
   output logic              partial,
   output logic              cmd_req,
   output logic [27:0]       cmd_lba,
   output logic [7:0]        cmd_nsectors,
   input  logic              cmd_ack,
   input  logic [15:0]       fifo_dout,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_en,
   input  logic              wr_full
);

   state_t            r_state;
   logic [LBA_W-1:0]  r_lba;
   logic [7:0]        r_nsec;
   logic [NB_W-1:0]   r_bursts;
   logic [16:0]       r_words;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_fill_data;
   logic              r_fill_en;
   logic              r_cmd_req;
   logic              r_partial;
   logic              r_inflight;

   logic              w_pk_valid;
   logic [DATA_W-1:0] w_pk_data;
   logic [2:0]        w_pk_cnt;
   logic              w_is_fill;
   logic              w_wr_en;
   logic              w_wr_acc;
   logic              w_pk_pop;
   logic              w_rd_en;
   logic              w_xfer_idle;
   logic              w_last;
   logic              w_clr;

   assign w_is_fill   = (r_state == ST_FILL);
   assign w_wr_en     = w_is_fill ? r_fill_en : w_pk_valid;
   assign w_wr_acc    = w_wr_en && !wr_full;
   assign w_pk_pop    = w_pk_valid && !wr_full;
   assign w_xfer_idle = (r_words == 17'd0) && !r_inflight && !w_pk_valid;
   assign w_last      = (r_bursts <= NB_W'(1));
   assign w_rd_en     = (r_state == ST_XFER) && !fifo_empty &&
                        (r_words != 17'd0) && !r_inflight && !w_pk_valid;
   // Leftover bytes are dropped on a fresh start and at the end of a load.
   assign w_clr       = ((r_state == ST_IDLE) && start) ||
                        ((r_state == ST_XFER) && w_xfer_idle && w_last);

   sysace_byte_packer #(
      .PIX_BYTES (PIX_BYTES),
      .DATA_W    (DATA_W)
   ) u_packer (
      .CLK80   (CLK80),
      .RST     (RST),
      .i_clr   (w_clr),
      .i_push  (r_inflight),
      .i_word  (fifo_dout),
      .i_pop   (w_pk_pop),
      .o_valid (w_pk_valid),
      .o_data  (w_pk_data),
      .o_cnt   (w_pk_cnt)
   );

   always_ff @(posedge CLK80 or negedge RST) begin
      if (!RST) begin
         r_state     <= ST_IDLE;
         r_lba       <= '0;
         r_nsec      <= '0;
         r_bursts    <= '0;
         r_words     <= '0;
         r_addr      <= '0;
         r_fill_data <= '0;
         r_fill_en   <= 1'b0;
         r_cmd_req   <= 1'b0;
         r_partial   <= 1'b0;
         r_inflight  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_lba       <= base_lba;
                  r_nsec      <= burst_sectors;
                  r_bursts    <= num_bursts;
                  r_addr      <= mode ? '0 : base_addr;
                  r_fill_data <= fill_pattern;
                  r_partial   <= 1'b0;
                  if (mode) begin
                     r_fill_en <= 1'b1;
                     r_state   <= ST_FILL;
                  end else if (num_bursts != '0) begin
                     r_cmd_req <= 1'b1;
                     r_state   <= ST_CMD;
                  end else begin
                     r_state   <= ST_DONE;
                  end
               end
            end
            ST_FILL: begin
               if (w_wr_acc) begin
                  r_addr <= r_addr + ADDR_W'(1);
                  if (r_addr == '1) begin
                     r_fill_en <= 1'b0;
                     r_state   <= ST_DONE;
                  end
               end
            end
            ST_CMD: begin
               if (cmd_ack) begin
                  r_cmd_req <= 1'b0;
                  r_state   <= ST_ACKLOW;
               end
            end
            ST_ACKLOW: begin
               if (!cmd_ack) begin
                  r_words <= sec_words(r_nsec);
                  r_state <= ST_XFER;
               end
            end
            ST_XFER: begin
               r_inflight <= w_rd_en;
               if (w_rd_en)
                  r_words <= r_words - 17'd1;
               if (w_wr_acc)
                  r_addr <= r_addr + ADDR_W'(1);
               if (w_xfer_idle) begin
                  if (!w_last) begin
                     r_bursts  <= r_bursts - NB_W'(1);
                     r_lba     <= r_lba + LBA_W'(sec_count(r_nsec));
                     r_cmd_req <= 1'b1;
                     r_state   <= ST_CMD;
                  end else begin
                     r_partial <= (w_pk_cnt != 3'd0);
                     r_state   <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy         = (r_state != ST_IDLE);
   assign done         = (r_state == ST_DONE);
   assign partial      = r_partial;
   assign cmd_req      = r_cmd_req;
   assign cmd_lba      = r_lba;
   assign cmd_nsectors = r_nsec;
   assign fifo_rd_en   = w_rd_en;
   assign wr_addr      = r_addr;
   assign wr_data      = w_is_fill ? r_fill_data : w_pk_data;
   assign wr_en        = w_wr_en;

endmodule
